// File: rtl/bp_fe_ras_ckpt.sv
// ---------------------------------------------------------------------------
// bp_fe_ras_ckpt -- checkpointable return address stack for the fetch frontend
//
// A circular stack of return addresses. Calls push, returns pop, and a
// call+return in the same cycle replaces the top entry (co-routine). The full
// speculative state {ptr, count, top value} is exported every cycle on ckpt_o
// so it can ride along with branch metadata; on a misprediction that snapshot
// is handed back on restore_ckpt_i to repair the stack.
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   reset_n_i      : asynchronous active-low reset (ptr/count only)
//   call_i         : push request
//   return_i       : pop request
//   addr_i         : return address to push
//   tgt_o          : top-of-stack address (meaningful when v_o)
//   v_o            : stack non-empty
//   full_o         : count == els_p
//   ckpt_o         : {ptr, count, top value} snapshot of the current state
//   restore_v_i    : misprediction repair request
//   restore_ckpt_i : checkpoint previously taken from ckpt_o
//   flush_i        : empty the stack
//
// There is no valid/ready handshake: every request is accepted in the cycle
// it is presented and its effect is visible on the outputs one cycle later.
// Priority per cycle: flush_i > restore_v_i > call_i/return_i.
// ---------------------------------------------------------------------------
module bp_fe_ras_ckpt #(
  parameter int vaddr_width_p = 39,
  parameter int els_p         = 8,
  localparam int ptr_width_lp  = $clog2(els_p),
  localparam int cnt_width_lp  = $clog2(els_p + 1),
  localparam int ckpt_width_lp = ptr_width_lp + cnt_width_lp + vaddr_width_p
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     call_i,
  input  logic                     return_i,
  input  logic [vaddr_width_p-1:0] addr_i,
  output logic [vaddr_width_p-1:0] tgt_o,
  output logic                     v_o,
  output logic [ckpt_width_lp-1:0] ckpt_o,
  input  logic                     restore_v_i,
  input  logic [ckpt_width_lp-1:0] restore_ckpt_i,
  input  logic                     flush_i,
  output logic                     full_o
);

  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);
  localparam logic [cnt_width_lp-1:0] one_cnt_lp  = cnt_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] one_ptr_lp  = ptr_width_lp'(1);

  logic [vaddr_width_p-1:0] r_mem [els_p];
  logic [ptr_width_lp-1:0]  r_ptr;
  logic [cnt_width_lp-1:0]  r_count;

  logic [ptr_width_lp-1:0]  w_ptr_n;
  logic [cnt_width_lp-1:0]  w_count_n;
  logic                     w_mem_we;
  logic [ptr_width_lp-1:0]  w_mem_waddr;
  logic [vaddr_width_p-1:0] w_mem_wdata;

  // Checkpoint field unpacking: {ptr, count, top value}
  logic [ptr_width_lp-1:0]  w_rst_ptr;
  logic [cnt_width_lp-1:0]  w_rst_cnt;
  logic [cnt_width_lp-1:0]  w_rst_cnt_clamped;
  logic [vaddr_width_p-1:0] w_rst_val;
  logic [vaddr_width_p-1:0] w_top;

  assign w_rst_ptr = restore_ckpt_i[ckpt_width_lp-1 -: ptr_width_lp];
  assign w_rst_cnt = restore_ckpt_i[vaddr_width_p +: cnt_width_lp];
  assign w_rst_val = restore_ckpt_i[vaddr_width_p-1:0];

  // A corrupted checkpoint must never leave count above the stack depth.
  assign w_rst_cnt_clamped = (w_rst_cnt > full_cnt_lp) ? full_cnt_lp : w_rst_cnt;

  assign w_top  = r_mem[r_ptr];
  assign tgt_o  = w_top;
  assign v_o    = (r_count != '0);
  assign full_o = (r_count == full_cnt_lp);
  assign ckpt_o = {r_ptr, r_count, w_top};

  always_comb begin
    w_ptr_n     = r_ptr;
    w_count_n   = r_count;
    w_mem_we    = 1'b0;
    w_mem_waddr = r_ptr;
    w_mem_wdata = addr_i;
    if (flush_i) begin
      w_ptr_n   = '0;
      w_count_n = '0;
    end else if (restore_v_i) begin
      // The saved top value may have been overwritten by wrong-path pushes,
      // so it is written back along with the pointer and count.
      w_ptr_n     = w_rst_ptr;
      w_count_n   = w_rst_cnt_clamped;
      w_mem_we    = 1'b1;
      w_mem_waddr = w_rst_ptr;
      w_mem_wdata = w_rst_val;
    end else if (call_i && !return_i) begin
      // When full the pointer simply wraps onto the oldest entry.
      w_ptr_n     = r_ptr + one_ptr_lp;
      w_mem_we    = 1'b1;
      w_mem_waddr = r_ptr + one_ptr_lp;
      w_count_n   = (r_count == full_cnt_lp) ? full_cnt_lp : r_count + one_cnt_lp;
    end else if (return_i && !call_i) begin
      if (r_count != '0) begin
        w_ptr_n   = r_ptr - one_ptr_lp;
        w_count_n = r_count - one_cnt_lp;
      end
    end else if (call_i && return_i) begin
      // Co-routine: the returning frame is replaced in place.
      w_mem_we    = 1'b1;
      w_mem_waddr = r_ptr;
      w_count_n   = (r_count == '0) ? one_cnt_lp : r_count;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else begin
      r_ptr   <= w_ptr_n;
      r_count <= w_count_n;
    end
  end

  // Storage is not reset; writes are suppressed while reset is held so a
  // request concurrent with reset leaves no trace.
  always_ff @(posedge clk_i) begin
    if (w_mem_we && reset_n_i) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

endmodule

// File: tb/tb_bp_fe_ras_ckpt.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_ras_ckpt -- self-checking bench for bp_fe_ras_ckpt (els_p = 8)
//
// A table of {call, return, flush, addr, expected count, ptr, top} records is
// applied one per clock; hand-written sequences cover checkpoint restore,
// restore clamping, flush priority and asynchronous reset. Expected state is
// pushed to exp_q when stimulus is driven and popped/compared one cycle later.
// ---------------------------------------------------------------------------
module tb_bp_fe_ras_ckpt;

  localparam int VW  = 39;
  localparam int ELS = 8;
  localparam int PW  = 3;
  localparam int CW  = 4;
  localparam int KW  = PW + CW + VW;
  localparam int EW  = 2 + PW + CW + VW;

  logic          clk;
  logic          rst_n;
  logic          call;
  logic          ret;
  logic          flush;
  logic          restore;
  logic [VW-1:0] addr;
  logic [KW-1:0] restore_ckpt;
  logic [VW-1:0] tgt;
  logic          v;
  logic          full;
  logic [KW-1:0] ckpt;

  bp_fe_ras_ckpt #(
    .vaddr_width_p(VW),
    .els_p        (ELS)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (rst_n),
    .call_i        (call),
    .return_i      (ret),
    .addr_i        (addr),
    .tgt_o         (tgt),
    .v_o           (v),
    .ckpt_o        (ckpt),
    .restore_v_i   (restore),
    .restore_ckpt_i(restore_ckpt),
    .flush_i       (flush),
    .full_o        (full)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic          call;
    logic          ret;
    logic          flush;
    logic [VW-1:0] addr;
    int            cnt;
    int            ptr;
    logic [VW-1:0] tgt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [EW-1:0] pack_exp(input int cnt, input int ptr,
                                             input logic [VW-1:0] t);
    logic ev;
    logic ef;
    ev = (cnt != 0);
    ef = (cnt == ELS);
    return {ev, ef, PW'(ptr), CW'(cnt), t};
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic compare_head(input string tag);
    logic [EW-1:0] e;
    logic          e_v;
    logic          e_full;
    logic [PW-1:0] e_ptr;
    logic [CW-1:0] e_cnt;
    logic [VW-1:0] e_tgt;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard queue empty", tag);
      return;
    end
    e      = exp_q.pop_front();
    e_v    = e[EW-1];
    e_full = e[EW-2];
    e_ptr  = e[EW-3 -: PW];
    e_cnt  = e[VW +: CW];
    e_tgt  = e[VW-1:0];
    check({tag, ".v"},    64'(v),                   64'(e_v));
    check({tag, ".full"}, 64'(full),                64'(e_full));
    check({tag, ".cnt"},  64'(ckpt[VW +: CW]),      64'(e_cnt));
    check({tag, ".ptr"},  64'(ckpt[KW-1 -: PW]),    64'(e_ptr));
    if (e_v) begin
      check({tag, ".tgt"},      64'(tgt),           64'(e_tgt));
      check({tag, ".ckpt_top"}, 64'(ckpt[VW-1:0]),  64'(e_tgt));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, input logic r, input logic f,
                       input logic [VW-1:0] a);
    call    = c;
    ret     = r;
    flush   = f;
    addr    = a;
    restore = 1'b0;
  endtask

  // Expectation is queued with the stimulus, checked #1 after the edge.
  task automatic step(input string tag, input int cnt, input int ptr,
                      input logic [VW-1:0] t);
    exp_q.push_back(pack_exp(cnt, ptr, t));
    @(posedge clk);
    #1;
    compare_head(tag);
  endtask

  task automatic expect_now(input string tag, input int cnt, input int ptr,
                            input logic [VW-1:0] t);
    exp_q.push_back(pack_exp(cnt, ptr, t));
    compare_head(tag);
  endtask

  function void add(input logic c, input logic r, input logic f,
                    input logic [VW-1:0] a, input int cnt, input int ptr,
                    input logic [VW-1:0] t);
    vec_t x;
    x.call  = c;
    x.ret   = r;
    x.flush = f;
    x.addr  = a;
    x.cnt   = cnt;
    x.ptr   = ptr;
    x.tgt   = t;
    vecs.push_back(x);
  endfunction

  // ---------------- test ----------------
  logic [KW-1:0] saved_ckpt;

  initial begin
    // Three pushes, three pops, one pop on empty
    add(1, 0, 0, 39'h100, 1, 1, 39'h100);
    add(1, 0, 0, 39'h200, 2, 2, 39'h200);
    add(1, 0, 0, 39'h300, 3, 3, 39'h300);
    add(0, 1, 0, 39'h0,   2, 2, 39'h200);
    add(0, 1, 0, 39'h0,   1, 1, 39'h100);
    add(0, 1, 0, 39'h0,   0, 0, 39'h0);
    add(0, 1, 0, 39'h0,   0, 0, 39'h0);
    // Nine pushes into an 8-deep stack: last one overwrites the oldest
    for (int k = 1; k <= 9; k++)
      add(1, 0, 0, VW'(16 * k), (k > ELS) ? ELS : k, k % ELS, VW'(16 * k));
    // Eight pops walk back 0x80..0x20 and then empty
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, 39'h0, 8 - k, (9 - k) % ELS, VW'(16'h90 - 16 * k));
    // Co-routine on {0x40, 0x50}, and on an empty stack
    add(1, 0, 0, 39'h40, 1, 2, 39'h40);
    add(1, 0, 0, 39'h50, 2, 3, 39'h50);
    add(1, 1, 0, 39'h60, 2, 3, 39'h60);
    add(0, 1, 0, 39'h0,  1, 2, 39'h40);
    add(0, 1, 0, 39'h0,  0, 1, 39'h0);
    add(1, 1, 0, 39'h70, 1, 1, 39'h70);
    add(0, 1, 0, 39'h0,  0, 0, 39'h0);
    // Flush, flush beating a push, idle
    add(1, 0, 0, 39'hAA, 1, 1, 39'hAA);
    add(0, 0, 1, 39'h0,  0, 0, 39'h0);
    add(1, 0, 1, 39'hBB, 0, 0, 39'h0);
    add(0, 0, 0, 39'h0,  0, 0, 39'h0);

    rst_n        = 1'b0;
    restore_ckpt = '0;
    drive(0, 0, 0, '0);
    #12;
    expect_now("reset", 0, 0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].call, vecs[i].ret, vecs[i].flush, vecs[i].addr);
      step($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ptr, vecs[i].tgt);
    end

    // Checkpoint capture and repair after wrong-path activity
    drive(1, 0, 0, 39'hA0);
    step("ck_push_a0", 1, 1, 39'hA0);
    saved_ckpt = ckpt;
    check("ck_capture", 64'(saved_ckpt), 64'({3'd1, 4'd1, 39'hA0}));
    drive(1, 0, 0, 39'hB0);
    step("ck_push_b0", 2, 2, 39'hB0);
    drive(0, 1, 0, '0);
    step("ck_pop1", 1, 1, 39'hA0);
    drive(0, 1, 0, '0);
    step("ck_pop2", 0, 0, '0);
    drive(1, 0, 0, 39'hC0);
    step("ck_push_c0", 1, 1, 39'hC0);
    drive(1, 0, 0, 39'hD0);
    restore      = 1'b1;
    restore_ckpt = saved_ckpt;
    step("ck_restore", 1, 1, 39'hA0);

    // Over-range checkpoint count is clamped to the depth
    drive(0, 1, 0, '0);
    restore      = 1'b1;
    restore_ckpt = {3'd5, 4'd15, 39'hDD};
    step("ck_clamp", 8, 5, 39'hDD);

    // Flush outranks restore and push in the same cycle
    drive(1, 0, 1, 39'h33);
    restore      = 1'b1;
    restore_ckpt = {3'd1, 4'd3, 39'hEE};
    step("flush_prio", 0, 0, '0);
    drive(1, 0, 0, 39'h44);
    step("post_flush_push", 1, 1, 39'h44);

    // Reset pulse between edges while a push is being presented
    drive(1, 0, 0, 39'h55);
    step("ar_push55", 2, 2, 39'h55);
    drive(1, 0, 0, 39'h66);
    step("ar_push66", 3, 3, 39'h66);
    drive(1, 0, 0, 39'h77);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_reset", 0, 0, '0);
    #1;
    rst_n = 1'b1;
    step("ar_first_push", 1, 1, 39'h77);

    // Reset held across an edge overrides the concurrent push
    drive(1, 0, 0, 39'h99);
    rst_n = 1'b0;
    step("reset_over_push", 0, 0, '0);
    rst_n = 1'b1;
    drive(1, 0, 0, 39'h88);
    step("post_reset_push", 1, 1, 39'h88);
    drive(0, 0, 0, '0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_ras_ckpt.md
BP_FE_RAS_CKPT -- requirements
Module: bp_fe_ras_ckpt

Interface
REQ-001 SHALL have parameter vaddr_width_p, default 39: width of return addresses.
REQ-002 SHALL have parameter els_p, default 8: stack depth; power of two, >= 2.
REQ-003 SHALL have derived localparams ptr_width_lp = log2(els_p) and cnt_width_lp = log2(els_p+1).
REQ-004 SHALL have derived localparam ckpt_width_lp = ptr_width_lp + cnt_width_lp + vaddr_width_p.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 call_i  input  1  push request (IF2 call site).
REQ-008 return_i  input  1  pop request (IF2 return site).
REQ-009 addr_i  input  vaddr_width_p  return address to push.
REQ-010 tgt_o  output  vaddr_width_p  top-of-stack address.
REQ-011 v_o  output  1  stack non-empty; tgt_o meaningful.
REQ-012 ckpt_o  output  ckpt_width_lp  {ptr, count, top value} snapshot, forwarded in branch metadata.
REQ-013 restore_v_i  input  1  misprediction repair request.
REQ-014 restore_ckpt_i  input  ckpt_width_lp  checkpoint previously emitted on ckpt_o.
REQ-015 flush_i  input  1  empty the stack (context switch / fence).
REQ-016 full_o  output  1  count == els_p.

Function
REQ-017 SHALL hold els_p-entry circular storage mem, top pointer ptr_r, occupancy count_r.
REQ-018 tgt_o SHALL equal mem[ptr_r] combinationally; v_o = (count_r != 0); full_o = (count_r == els_p).
REQ-019 ckpt_o SHALL equal {ptr_r, count_r, mem[ptr_r]} combinationally, reflecting pre-update state of the current cycle.
REQ-020 Push only (call_i & ~return_i): ptr_r <= ptr_r+1 mod els_p; mem[ptr_r+1] <= addr_i; count_r <= min(count_r+1, els_p).
REQ-021 Push when full SHALL overwrite the oldest entry (wrap-around); count_r stays els_p.
REQ-022 Pop only (return_i & ~call_i) with count_r != 0: ptr_r <= ptr_r-1 mod els_p; count_r <= count_r-1; mem unchanged.
REQ-023 Pop when empty SHALL be a no-op on all state.
REQ-024 Call and return same cycle (co-routine): mem[ptr_r] <= addr_i; ptr_r unchanged; count_r <= max(count_r, 1).
REQ-025 restore_v_i SHALL load ptr_r and count_r from restore_ckpt_i and write the saved top value into mem[saved ptr]; call_i/return_i ignored that cycle.
REQ-026 flush_i SHALL set count_r <= 0 and ptr_r <= 0; mem contents unchanged.
REQ-027 Priority: flush_i > restore_v_i > call_i/return_i.
REQ-028 All updates SHALL be visible on tgt_o/v_o/ckpt_o the cycle after the triggering edge; latency 1, no stalls, no handshake.
REQ-029 Pointer arithmetic SHALL be modulo els_p via ptr_width_lp-bit wrap; count arithmetic saturates at 0 and els_p.
REQ-030 Restore with checkpoint count > els_p SHALL be treated as count els_p (defensive clamp).

Reset
REQ-031 On reset_n_i low, asynchronously: ptr_r = 0, count_r = 0; v_o = 0, full_o = 0, ckpt_o ptr/count fields = 0.
REQ-032 mem SHALL not require reset; tgt_o value is don't-care while v_o = 0.
REQ-033 Reset asserted mid-operation SHALL override any concurrent call/return/restore; first post-reset push lands in mem[1].

Verification
REQ-034 Reset, push 0x100, 0x200, 0x300 -> tgt_o 0x300, count 3, v_o 1; three pops -> v_o 0; fourth pop -> state unchanged.
REQ-035 els_p=8: push 0x10..0x90 (9 entries) -> full_o 1, count 8, tgt_o 0x90; 8 pops return 0x90..0x20, then v_o 0.
REQ-036 Push 0xA0, capture ckpt_o, push 0xB0, pop, pop, push 0xC0 (corrupts entry), restore_v_i with captured ckpt -> tgt_o 0xA0, count as captured.
REQ-037 Stack {0x40,0x50}: call_i & return_i with addr 0x60 -> tgt_o 0x60, count 2; pop -> tgt_o 0x40.
REQ-038 Same cycle flush_i, restore_v_i, call_i -> count 0, v_o 0; restore and push discarded.
REQ-039 Deassert-reassert reset_n_i between clock edges while pushing -> count 0 immediately, no edge required.
